// File: rtl/mips_prog_loader_if.sv
// Bus bundle between the program loader and its surroundings: the program
// word stream, the unified memory port, the core control lines and the
// readback stream. The loader side is "master"; memory, core and the
// stream endpoints together form the "slave" side.
interface mips_prog_loader_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   // program word stream into the loader
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_ready;

   // unified memory port
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_own;

   // core control
   logic              cpu_pc_load;
   logic [ADDR_W-1:0] cpu_pc_value;
   logic              cpu_run;
   logic              cpu_halted;

   // readback stream out of the loader
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;

   modport master (
      input  in_valid, in_data, in_last,
      output in_ready,
      output mem_we, mem_addr, mem_wdata, mem_own,
      input  mem_rdata,
      output cpu_pc_load, cpu_pc_value, cpu_run,
      input  cpu_halted,
      output out_valid, out_data, out_last,
      input  out_ready
   );

   modport slave (
      output in_valid, in_data, in_last,
      input  in_ready,
      input  mem_we, mem_addr, mem_wdata, mem_own,
      output mem_rdata,
      input  cpu_pc_load, cpu_pc_value, cpu_run,
      output cpu_halted,
      input  out_valid, out_data, out_last,
      output out_ready
   );
endinterface

// File: rtl/mips_prog_loader.sv
// Program loader / run sequencer for the pipelined MIPS32 core.
// Streams a program into unified memory, loads the start PC, lets the core
// run until it halts (or a cycle budget expires), then streams a window of
// data memory back out.
module mips_prog_loader #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 4000
) (
   input  logic               clk1,
   input  logic               reset,
   input  logic               go,
   input  logic [ADDR_W-1:0]  cfg_load_base,
   input  logic [ADDR_W-1:0]  cfg_start_pc,
   input  logic [ADDR_W-1:0]  cfg_dump_base,
   input  logic [CNT_W-1:0]   cfg_dump_len,
   mips_prog_loader_if.master bus,
   output logic               busy,
   output logic               done,
   output logic               timeout_err,
   output logic [CNT_W-1:0]   run_cycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_INIT,
      S_RUN,
      S_DUMP_RD,
      S_DUMP_OUT,
      S_DONE
   } state_t;

   // last RUN cycle allowed before abort (run counter starts at 0)
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] start_pc;
   logic [CNT_W-1:0]  dump_len;
   logic [CNT_W-1:0]  dump_left;
   logic [CNT_W-1:0]  run_cnt;
   logic              timeout_q;
   logic [DATA_W-1:0] rdata_q;
   logic              first_q;
   logic              to_hit;

   assign to_hit = (TIMEOUT != 0) && (run_cnt == TO_LAST);

   // state register
   always_ff @(posedge clk1) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (go) state_nxt = S_LOAD;
         S_LOAD:         if (bus.in_valid && bus.in_last) state_nxt = S_INIT;
         S_INIT:         state_nxt = S_RUN;
         S_RUN: begin
            // halt has priority over a coincident timeout
            if (bus.cpu_halted)  state_nxt = (dump_len != '0) ? S_DUMP_RD : S_DONE;
            else if (to_hit)     state_nxt = S_DONE;
         end
         S_DUMP_RD:      state_nxt = S_DUMP_OUT;
         S_DUMP_OUT: begin
            if (bus.out_ready) state_nxt = (dump_left == CNT_W'(1)) ? S_DONE : S_DUMP_RD;
         end
         default:        state_nxt = S_IDLE;
      endcase
   end

   // per-state outputs, all derived from the current state
   always_comb begin
      bus.in_ready    = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = '0;
      bus.mem_own     = 1'b0;
      bus.cpu_pc_load = 1'b0;
      bus.cpu_run     = 1'b0;
      bus.out_valid   = 1'b0;
      bus.out_last    = 1'b0;
      busy            = 1'b0;
      done            = 1'b0;
      case (state)
         S_LOAD: begin
            busy          = 1'b1;
            bus.mem_own   = 1'b1;
            bus.in_ready  = 1'b1;
            // write strobe follows the handshake combinationally
            bus.mem_we    = bus.in_valid;
            bus.mem_addr  = wr_addr;
            bus.mem_wdata = bus.in_data;
         end
         S_INIT: begin
            busy            = 1'b1;
            bus.cpu_pc_load = 1'b1;
         end
         S_RUN: begin
            busy        = 1'b1;
            bus.cpu_run = 1'b1;
         end
         S_DUMP_RD: begin
            busy         = 1'b1;
            bus.mem_own  = 1'b1;
            bus.mem_addr = rd_addr;
         end
         S_DUMP_OUT: begin
            busy          = 1'b1;
            bus.mem_own   = 1'b1;
            bus.mem_addr  = rd_addr;
            bus.out_valid = 1'b1;
            bus.out_last  = (dump_left == CNT_W'(1));
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // session configuration, load/dump addresses, run counter and error flag
   always_ff @(posedge clk1) begin
      if (reset) begin
         wr_addr   <= '0;
         rd_addr   <= '0;
         start_pc  <= '0;
         dump_len  <= '0;
         dump_left <= '0;
         run_cnt   <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (go) begin
                  wr_addr   <= cfg_load_base;
                  rd_addr   <= cfg_dump_base;
                  start_pc  <= cfg_start_pc;
                  dump_len  <= cfg_dump_len;
                  dump_left <= cfg_dump_len;
                  run_cnt   <= '0;
                  timeout_q <= 1'b0;
               end
            end
            S_LOAD: begin
               if (bus.in_valid) wr_addr <= wr_addr + ADDR_W'(1);
            end
            S_RUN: begin
               if (run_cnt != '1) run_cnt <= run_cnt + CNT_W'(1);
               if (!bus.cpu_halted && to_hit) timeout_q <= 1'b1;
            end
            S_DUMP_OUT: begin
               if (bus.out_ready) begin
                  rd_addr   <= rd_addr + ADDR_W'(1);
                  dump_left <= dump_left - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // hold the read word so out_data stays put while the consumer stalls
   always_ff @(posedge clk1) begin
      if (reset) begin
         first_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         first_q <= (state == S_DUMP_RD);
         if (first_q) rdata_q <= bus.mem_rdata;
      end
   end

   // first DUMP_OUT cycle forwards the fresh memory word, later cycles the held copy
   assign bus.out_data     = first_q ? bus.mem_rdata : rdata_q;
   assign bus.cpu_pc_value = start_pc;
   assign timeout_err      = timeout_q;
   assign run_cycles       = run_cnt;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader with a behavioural unified memory and a
// core model that halts after a programmable number of RUN cycles.
module tb_mips_prog_loader;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 32;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 50;
   localparam logic [31:0] HLT = 32'hfc00_0000;

   logic              clk1 = 1'b0;
   logic              reset;
   logic              go;
   logic [ADDR_W-1:0] cfg_load_base, cfg_start_pc, cfg_dump_base;
   logic [CNT_W-1:0]  cfg_dump_len;
   logic              busy, done, timeout_err;
   logic [CNT_W-1:0]  run_cycles;

   mips_prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mips_prog_loader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk1(clk1), .reset(reset), .go(go),
      .cfg_load_base(cfg_load_base), .cfg_start_pc(cfg_start_pc),
      .cfg_dump_base(cfg_dump_base), .cfg_dump_len(cfg_dump_len),
      .bus(bus),
      .busy(busy), .done(done), .timeout_err(timeout_err), .run_cycles(run_cycles)
   );

   always #5 clk1 = ~clk1;

   int tests = 0;
   int fails = 0;

   logic [31:0]       mem [0:1023];
   logic [31:0]       prog [0:15];
   logic [ADDR_W-1:0] wlog [$];
   int                we_cnt = 0;
   int                ov_cnt = 0;
   int                run_seen = 0;

   // core model state
   int          halt_after = 0;
   int          rc = 0;
   logic        halted = 1'b0;
   logic        core_we = 1'b0;
   logic [31:0] core_wdata = '0;

   function automatic logic [31:0] fact(input logic [31:0] n);
      logic [31:0] r = 1;
      for (int i = 2; i <= 12; i++) if (i <= n) r = r * i;
      return r;
   endfunction

   // core: counts RUN cycles, raises halted in the halt_after-th one and
   // stores fact(mem[200]) at 198 as the factorial program would
   always @(negedge clk1) begin
      core_we <= 1'b0;
      if (reset || bus.cpu_pc_load) begin
         rc     <= 0;
         halted <= 1'b0;
      end else if (bus.cpu_run && !halted) begin
         rc <= rc + 1;
         if (halt_after != 0 && rc + 1 == halt_after) begin
            halted     <= 1'b1;
            core_we    <= 1'b1;
            core_wdata <= fact(mem[200]);
         end
      end
   end
   assign bus.cpu_halted = halted;

   // unified memory with registered read, plus activity counters
   always @(posedge clk1) begin
      if (bus.mem_own && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else if (!bus.mem_own && core_we) mem[198] <= core_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we) begin
         we_cnt <= we_cnt + 1;
         wlog.push_back(bus.mem_addr);
      end
      if (bus.out_valid) ov_cnt <= ov_cnt + 1;
      if (bus.cpu_run) run_seen <= run_seen + 1;
   end

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic start(input logic [ADDR_W-1:0] lb, input logic [ADDR_W-1:0] pc,
                        input logic [ADDR_W-1:0] db, input logic [CNT_W-1:0] len);
      cfg_load_base = lb; cfg_start_pc = pc; cfg_dump_base = db; cfg_dump_len = len;
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   task automatic send_prog(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            bus.in_valid = 1'b0;
            for (int k = 0; k < g; k++) tick();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = prog[i];
         bus.in_last  = (i == n - 1);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit ok);
      int c = 0;
      while (!done && c < bound) begin tick(); c++; end
      ok = done;
   endtask

   task automatic recv(output logic [31:0] d, output logic l, output bit ok);
      int c = 0;
      bus.out_ready = 1'b1;
      while (!bus.out_valid && c < 200) begin tick(); c++; end
      ok = bus.out_valid; d = bus.out_data; l = bus.out_last;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      int n0;
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      tests++; if ({busy, done, timeout_err, bus.in_ready, bus.out_valid, bus.out_last, bus.mem_we,
                    bus.mem_own, bus.cpu_run, bus.cpu_pc_load} !== 10'b0) begin
         fails++; $display("FAIL reset_flags: got %b required 0", {busy, done, timeout_err, bus.in_ready,
                   bus.out_valid, bus.out_last, bus.mem_we, bus.mem_own, bus.cpu_run, bus.cpu_pc_load});
      end
      tests++; if (run_cycles !== '0) begin fails++; $display("FAIL reset_run_cycles: got %0d required 0", run_cycles); end
      tests++; if ({bus.mem_addr, bus.mem_wdata, bus.out_data} !== '0) begin
         fails++; $display("FAIL reset_buses: addr %0d wdata %0h out %0h required 0", bus.mem_addr, bus.mem_wdata, bus.out_data);
      end
      // words offered while idle must not be consumed
      n0 = we_cnt;
      bus.in_valid = 1'b1; bus.in_data = 32'hdead_beef;
      tick();
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL idle_in_ready: got %b required 0", bus.in_ready); end
      tick(); tick();
      bus.in_valid = 1'b0;
      tests++; if (we_cnt - n0 != 0) begin fails++; $display("FAIL idle_writes: got %0d required 0", we_cnt - n0); end
   endtask

   task automatic test_factorial();
      bit k, k0, k1, k2;
      logic [31:0] d0, d1, d2;
      logic l0, l1, l2;
      // session 1: data word 7 at 200, core halts on its first RUN cycle
      prog[0] = 32'd7; halt_after = 1;
      start(10'd200, 10'd200, 10'd198, 16'd0);
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL load_in_ready: got %b required 1", bus.in_ready); end
      send_prog(1, 1'b0);
      wait_done(100, k);
      tests++; if (!k) begin fails++; $display("FAIL fact_s1_done: got 0 required 1"); end
      tests++; if (mem[200] !== 32'd7) begin fails++; $display("FAIL fact_data7: got %0d required 7", mem[200]); end
      // session 2: 11-word factorial program at 0, dump 198..200
      prog[0] = 32'h280a_00c8; prog[1] = 32'h2802_0001; prog[2]  = 32'h0e94_a000;
      prog[3] = 32'h2143_0000; prog[4] = 32'h0e94_a000; prog[5]  = 32'h1443_1000;
      prog[6] = 32'h2c63_0001; prog[7] = 32'h0e94_a000; prog[8]  = 32'h3460_fffc;
      prog[9] = 32'h2542_fffe; prog[10] = HLT;
      halt_after = 30;
      start(10'd0, 10'd0, 10'd198, 16'd3);
      send_prog(11, 1'b0);
      for (int i = 0; i < 11; i++) begin
         tests++; if (mem[i] !== prog[i]) begin fails++; $display("FAIL fact_prog[%0d]: got %h required %h", i, mem[i], prog[i]); end
      end
      recv(d0, l0, k0); recv(d1, l1, k1); recv(d2, l2, k2);
      tests++; if ({k0, k1, k2} !== 3'b111) begin fails++; $display("FAIL fact_valid: got %b required 111", {k0, k1, k2}); end
      tests++; if (d0 !== 32'd5040) begin fails++; $display("FAIL fact_word0: got %0d required 5040", d0); end
      tests++; if (d2 !== 32'd7) begin fails++; $display("FAIL fact_word2: got %0d required 7", d2); end
      tests++; if ({l0, l1, l2} !== 3'b001) begin fails++; $display("FAIL fact_last: got %b required 001", {l0, l1, l2}); end
      tests++; if (done !== 1'b1 || timeout_err !== 1'b0) begin
         fails++; $display("FAIL fact_end: done %b timeout_err %b required 1 0", done, timeout_err);
      end
   endtask

   task automatic test_load_backpressure();
      bit k;
      int n0, w0;
      for (int i = 0; i < 8; i++) prog[i] = 32'ha5a5_0000 + i;
      halt_after = 3; n0 = we_cnt; w0 = wlog.size();
      start(10'd1022, 10'd1021, 10'd0, 16'd0);
      send_prog(8, 1'b1);
      tests++; if (bus.cpu_pc_load !== 1'b1 || bus.cpu_pc_value !== 10'd1021) begin
         fails++; $display("FAIL init_after_last: pc_load %b pc %0d required 1 1021", bus.cpu_pc_load, bus.cpu_pc_value);
      end
      tick();
      tests++; if (bus.cpu_pc_load !== 1'b0 || bus.cpu_run !== 1'b1) begin
         fails++; $display("FAIL init_one_cycle: pc_load %b run %b required 0 1", bus.cpu_pc_load, bus.cpu_run);
      end
      wait_done(100, k);
      tests++; if (we_cnt - n0 != 8) begin fails++; $display("FAIL bp_we_count: got %0d required 8", we_cnt - n0); end
      for (int i = 0; i < 8; i++) begin
         logic [ADDR_W-1:0] ea;
         ea = ADDR_W'((1022 + i) % 1024);
         tests++; if (wlog[w0 + i] !== ea || mem[ea] !== prog[i]) begin
            fails++; $display("FAIL bp_write[%0d]: addr %0d data %h required %0d %h", i, wlog[w0 + i], mem[ea], ea, prog[i]);
         end
      end
   endtask

   task automatic test_halt_37();
      bit k;
      int o0;
      prog[0] = HLT; halt_after = 37; o0 = ov_cnt;
      start(10'd100, 10'd100, 10'd50, 16'd0);
      send_prog(1, 1'b0);
      wait_done(200, k);
      tests++; if (!k) begin fails++; $display("FAIL h37_done: got 0 required 1"); end
      tests++; if (run_cycles !== 16'd37) begin fails++; $display("FAIL h37_run_cycles: got %0d required 37", run_cycles); end
      tests++; if (ov_cnt - o0 != 0) begin fails++; $display("FAIL h37_no_dump: got %0d valid cycles required 0", ov_cnt - o0); end
      tests++; if (timeout_err !== 1'b0 || bus.cpu_run !== 1'b0) begin
         fails++; $display("FAIL h37_flags: timeout_err %b run %b required 0 0", timeout_err, bus.cpu_run);
      end
   endtask

   task automatic test_timeout();
      bit k;
      int o0, r0;
      prog[0] = 32'h0000_0000; halt_after = 0; o0 = ov_cnt; r0 = run_seen;
      start(10'd20, 10'd20, 10'd20, 16'd4);
      send_prog(1, 1'b0);
      wait_done(300, k);
      tests++; if (!k || timeout_err !== 1'b1) begin fails++; $display("FAIL to_flag: done %b timeout_err %b required 1 1", k, timeout_err); end
      tests++; if (run_cycles !== 16'd50 || run_seen - r0 != 50) begin
         fails++; $display("FAIL to_cycles: counter %0d run-high %0d required 50 50", run_cycles, run_seen - r0);
      end
      tests++; if (bus.cpu_run !== 1'b0 || ov_cnt - o0 != 0) begin
         fails++; $display("FAIL to_stop: run %b valid cycles %0d required 0 0", bus.cpu_run, ov_cnt - o0);
      end
   endtask

   task automatic test_out_backpressure();
      bit k, k0, k1, k2, stable;
      int c;
      logic [31:0] d0, d1, d2;
      logic l0, l1, l2;
      prog[0] = 32'h1111_0001; prog[1] = 32'h2222_0002; prog[2] = 32'h3333_0003;
      halt_after = 2;
      start(10'd300, 10'd300, 10'd300, 16'd3);
      send_prog(3, 1'b0);
      bus.out_ready = 1'b0;
      c = 0;
      while (!bus.out_valid && c < 100) begin tick(); c++; end
      k = bus.out_valid;
      tests++; if (!k || bus.out_data !== prog[0]) begin fails++; $display("FAIL obp_first: valid %b data %h required 1 %h", k, bus.out_data, prog[0]); end
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.out_valid !== 1'b1 || bus.out_data !== prog[0] || bus.out_last !== 1'b0) stable = 1'b0;
      end
      tests++; if (!stable) begin fails++; $display("FAIL obp_stable: got unstable output required held word %h", prog[0]); end
      recv(d0, l0, k0); recv(d1, l1, k1); recv(d2, l2, k2);
      tests++; if ({d0, d1, d2} !== {prog[0], prog[1], prog[2]}) begin
         fails++; $display("FAIL obp_words: got %h %h %h required %h %h %h", d0, d1, d2, prog[0], prog[1], prog[2]);
      end
      tests++; if ({k0, k1, k2, l0, l1, l2, done} !== 7'b1110011) begin
         fails++; $display("FAIL obp_flags: got %b required 1110011", {k0, k1, k2, l0, l1, l2, done});
      end
   endtask

   task automatic test_reset_mid_run();
      prog[0] = HLT; halt_after = 0;
      start(10'd10, 10'd10, 10'd20, 16'd2);
      send_prog(1, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      tests++; if (bus.cpu_run !== 1'b1 || run_cycles === '0) begin
         fails++; $display("FAIL mid_run_pre: run %b cycles %0d required 1 nonzero", bus.cpu_run, run_cycles);
      end
      reset = 1'b1; tick(); reset = 1'b0;
      tests++; if ({busy, done, timeout_err, bus.cpu_run, bus.mem_own, bus.in_ready, bus.out_valid} !== 7'b0 || run_cycles !== '0) begin
         fails++; $display("FAIL mid_run_reset: flags %b cycles %0d required 0 0",
                  {busy, done, timeout_err, bus.cpu_run, bus.mem_own, bus.in_ready, bus.out_valid}, run_cycles);
      end
      tick(); tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_run_idle: busy %b required 0", busy); end
   endtask

   task automatic test_go_while_busy();
      bit k;
      int w0;
      prog[0] = 32'h0000_1234; prog[1] = 32'h0000_5678; halt_after = 0; w0 = wlog.size();
      start(10'd500, 10'd500, 10'd0, 16'd0);
      // go and a new base while loading: neither may take effect
      cfg_load_base = 10'd600; go = 1'b1; tick(); go = 1'b0;
      send_prog(2, 1'b0);
      tests++; if (wlog[w0] !== 10'd500 || wlog[w0 + 1] !== 10'd501) begin
         fails++; $display("FAIL busy_go_load: got %0d %0d required 500 501", wlog[w0], wlog[w0 + 1]);
      end
      for (int i = 0; i < 5; i++) tick();
      go = 1'b1; tick(); go = 1'b0;
      tests++; if (bus.cpu_run !== 1'b1 || busy !== 1'b1) begin
         fails++; $display("FAIL busy_go_run: run %b busy %b required 1 1", bus.cpu_run, busy);
      end
      wait_done(300, k);
      tests++; if (timeout_err !== 1'b1 || run_cycles !== 16'd50) begin
         fails++; $display("FAIL busy_go_timeout: err %b cycles %0d required 1 50", timeout_err, run_cycles);
      end
      // restart from DONE clears the sticky error and the counter
      prog[0] = HLT; halt_after = 4;
      start(10'd700, 10'd700, 10'd0, 16'd0);
      tests++; if ({busy, done, timeout_err} !== 3'b100 || run_cycles !== '0) begin
         fails++; $display("FAIL restart_clears: busy/done/err %b cycles %0d required 100 0", {busy, done, timeout_err}, run_cycles);
      end
      send_prog(1, 1'b0);
      wait_done(100, k);
      tests++; if (!k || run_cycles !== 16'd4 || timeout_err !== 1'b0) begin
         fails++; $display("FAIL restart_run: done %b cycles %0d err %b required 1 4 0", k, run_cycles, timeout_err);
      end
   endtask

   initial begin
      reset = 1'b1; go = 1'b0;
      cfg_load_base = '0; cfg_start_pc = '0; cfg_dump_base = '0; cfg_dump_len = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      test_reset();
      test_factorial();
      test_load_backpressure();
      test_halt_37();
      test_timeout();
      test_out_backpressure();
      test_reset_mid_run();
      test_go_while_busy();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
